threshold_fifo_queue: RTL and testbench
=======================================

THRESHOLD_FIFO_QUEUE -- requirements
Module: threshold_fifo_queue

Interface
REQ-001 SHALL have parameter SINGLE_ENTRY_WIDTH_IN_BITS, default 64, the entry data width.
REQ-002 SHALL have parameter QUEUE_SIZE, default 16, the entry count; power of two, 2..1024.
REQ-003 SHALL have parameter QUEUE_PTR_WIDTH_IN_BITS, default 4, equal to log2(QUEUE_SIZE).
REQ-004 SHALL have parameter ALMOST_FULL_THRESHOLD, default 12, the occupancy at or above which almost-full asserts.
REQ-005 SHALL have parameter ALMOST_EMPTY_THRESHOLD, default 4, the occupancy at or below which almost-empty asserts.
REQ-006 SHALL have one clock and a synchronous active-high reset; the clock is clk_in and the reset is reset_in.
REQ-007 SHALL have port clk_in  in  1  clock; all state changes on its rising edge.
REQ-008 SHALL have port reset_in  in  1  synchronous active-high reset.
REQ-009 SHALL have port request_in  in  SINGLE_ENTRY_WIDTH_IN_BITS  write data.
REQ-010 SHALL have port request_valid_in  in  1  write request.
REQ-011 SHALL have port issue_ack_out  out  1  write accepted this cycle.
REQ-012 SHALL have port request_out  out  SINGLE_ENTRY_WIDTH_IN_BITS  head entry data.
REQ-013 SHALL have port request_valid_out  out  1  head entry valid.
REQ-014 SHALL have port issue_ack_in  in  1  consumer pops the head entry.
REQ-015 SHALL have port is_empty_out  out  1  occupancy == 0.
REQ-016 SHALL have port is_full_out  out  1  occupancy == QUEUE_SIZE.
REQ-017 SHALL have port is_almost_full_out  out  1  occupancy >= ALMOST_FULL_THRESHOLD.
REQ-018 SHALL have port is_almost_empty_out  out  1  occupancy <= ALMOST_EMPTY_THRESHOLD.
REQ-019 SHALL have port occupancy_out  out  QUEUE_PTR_WIDTH_IN_BITS+1  current entry count.

Function
REQ-020 SHALL combinationally drive issue_ack_out = request_valid_in & ~is_full_out; a push occurs on every cycle where issue_ack_out is 1.
REQ-021 SHALL combinationally drive request_valid_out = ~is_empty_out; a pop occurs on every cycle where request_valid_out & issue_ack_in is 1.
REQ-022 SHALL treat issue_ack_in while empty as a no-op: no pointer or occupancy change.
REQ-023 SHALL write a pushed entry at the write pointer; the entry is visible on request_out one cycle after the push edge (latency 1).
REQ-024 SHALL drive request_out from storage at the read pointer; its value while request_valid_out=0 is don't-care.
REQ-025 SHALL wrap both pointers modulo QUEUE_SIZE.
REQ-026 SHALL keep occupancy as a registered counter: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-027 SHALL, when full with a simultaneous pop, pop only and refuse the push (issue_ack_out=0), so there is no combinational path from issue_ack_in to issue_ack_out.
REQ-028 SHALL, when empty with a simultaneous push, push only; no same-cycle bypass.
REQ-029 SHALL derive all status outputs from the registered occupancy, so they update one cycle after the push/pop edge.
REQ-030 SHALL reject at elaboration ALMOST_FULL_THRESHOLD > QUEUE_SIZE or ALMOST_EMPTY_THRESHOLD >= ALMOST_FULL_THRESHOLD.

Reset
REQ-031 SHALL, on reset_in=1 at a clock edge, clear both pointers and occupancy, giving is_empty_out=1, is_full_out=0, is_almost_empty_out=1, is_almost_full_out=0, occupancy_out=0 and request_valid_out=0 on the next cycle.
REQ-032 SHALL give reset_in priority over any push, pop or flush in the same cycle; storage contents are not cleared.

Configuration
REQ-033 SHALL provide macro THRESHOLD_FIFO_FLUSH_EN; when it is defined, port flush_in (in, 1) exists and flush_in=1 clears pointers and occupancy exactly like reset, discarding any same-cycle push (issue_ack_out forced to 0).
REQ-034 SHALL, when THRESHOLD_FIFO_FLUSH_EN is undefined, have no flush_in port and otherwise identical behaviour.

Structure
REQ-035 SHALL import shared package fifo_queue_pkg, which holds the default-width/depth constants and the occupancy-width helper function.
REQ-036 SHALL put pointer/occupancy logic in sub-module fifo_ptr_ctrl and keep the storage array in the top module.

Verification
REQ-037 SHALL cover basic order: push 8 entries 0xFFFF_FFFF_FFFF_FFFF-i, then pop -> values return in order, occupancy_out 8->0, is_empty_out=1 at end.
REQ-038 SHALL cover full: hold request_valid_in for 32 cycles with no pops -> exactly 16 acks, is_full_out=1, is_almost_full_out=1 from occupancy 12, then 16 pops return the first 16 values.
REQ-039 SHALL cover full plus pop: at occupancy 16 push and pop in the same cycle -> pop occurs, push is refused, occupancy becomes 15.
REQ-040 SHALL cover steady state: at occupancy 5, push and pop together for 40 cycles -> occupancy stays 5, pointers wrap, data order is preserved.
REQ-041 SHALL cover empty pop: issue_ack_in=1 while empty -> no change; with flush enabled, flush_in at occupancy 9 -> occupancy 0 the next cycle and the same-cycle push is refused.
REQ-042 SHALL cover mid-operation reset: reset_in at occupancy 7 -> all status values return to their reset values the next cycle.

Source files
------------

// File: rtl/fifo_queue_pkg.sv
// Shared constants and helpers for the threshold FIFO queue.
// Holds the default width/depth/threshold constants, the occupancy
// update encoding and the occupancy-width helper.
package fifo_queue_pkg;

   localparam int DEFAULT_ENTRY_WIDTH  = 64;
   localparam int DEFAULT_QUEUE_SIZE   = 16;
   localparam int DEFAULT_PTR_WIDTH    = 4;
   localparam int DEFAULT_ALMOST_FULL  = 12;
   localparam int DEFAULT_ALMOST_EMPTY = 4;

   // Occupancy update selected by {push, pop}
   typedef enum logic [1:0] {
      OCC_HOLD = 2'b00,
      OCC_DEC  = 2'b01,
      OCC_INC  = 2'b10,
      OCC_BOTH = 2'b11
   } occ_op_e;

   // The counter must represent 0..QUEUE_SIZE inclusive, hence one extra bit.
   function automatic int occ_width(input int ptr_width);
      return ptr_width + 1;
   endfunction

   function automatic bit is_pow2(input int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer and occupancy control for the threshold FIFO queue.
// Decides push/pop for each cycle, advances the wrapping read/write
// pointers and keeps the registered occupancy from which every status
// flag is derived.
module fifo_ptr_ctrl
   import fifo_queue_pkg::*;
#(
   parameter int QUEUE_SIZE = DEFAULT_QUEUE_SIZE,
   parameter int PTR_W      = DEFAULT_PTR_WIDTH,
   parameter int AF_THRESH  = DEFAULT_ALMOST_FULL,
   parameter int AE_THRESH  = DEFAULT_ALMOST_EMPTY
) (
   input  logic             clk_in,
   input  logic             reset_in,
   input  logic             push_req_i,
   input  logic             pop_req_i,
   input  logic             flush_i,
   output logic             push_o,
   output logic             pop_o,
   output logic [PTR_W-1:0] wr_ptr_o,
   output logic [PTR_W-1:0] rd_ptr_o,
   output logic [PTR_W:0]   occupancy_o,
   output logic             empty_o,
   output logic             full_o,
   output logic             almost_full_o,
   output logic             almost_empty_o
);

   localparam int OCC_W = occ_width(PTR_W);
   localparam logic [OCC_W-1:0] FULL_LVL = OCC_W'(QUEUE_SIZE);
   localparam logic [OCC_W-1:0] AF_LVL   = OCC_W'(AF_THRESH);
   localparam logic [OCC_W-1:0] AE_LVL   = OCC_W'(AE_THRESH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   occ_op_e          occ_op;

   // Status flags come only from the registered count, never from this cycle's requests
   assign empty_o        = (occ_q == '0);
   assign full_o         = (occ_q == FULL_LVL);
   assign almost_full_o  = (occ_q >= AF_LVL);
   assign almost_empty_o = (occ_q <= AE_LVL);
   assign occupancy_o    = occ_q;
   assign wr_ptr_o       = wr_ptr_q;
   assign rd_ptr_o       = rd_ptr_q;

   // A full queue refuses pushes even if it pops this cycle, keeping the
   // consumer's ack out of the producer's ack path; flush discards both.
   assign push_o = push_req_i & ~full_o & ~flush_i;
   assign pop_o  = pop_req_i & ~empty_o & ~flush_i;
   assign occ_op = occ_op_e'({push_o, pop_o});

   // Next-state pointers and occupancy; pointers wrap naturally at 2**PTR_W
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (push_o) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_o)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         unique case (occ_op)
            OCC_INC:  occ_d = occ_q + OCC_W'(1);
            OCC_DEC:  occ_d = occ_q - OCC_W'(1);
            OCC_BOTH: occ_d = occ_q;
            default:  occ_d = occ_q;
         endcase
      end
   end

   // State registers; reset overrides any push, pop or flush
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

endmodule

// File: rtl/threshold_fifo_queue.sv
// Threshold FIFO queue: single-clock FIFO with full/empty and
// almost-full/almost-empty flags. Storage lives here; pointer and
// occupancy control lives in fifo_ptr_ctrl.
// Optional feature macro: THRESHOLD_FIFO_FLUSH_EN adds a flush_in port
// that clears the queue like reset and refuses the same-cycle push.
module threshold_fifo_queue
   import fifo_queue_pkg::*;
#(
   parameter int SINGLE_ENTRY_WIDTH_IN_BITS = DEFAULT_ENTRY_WIDTH,
   parameter int QUEUE_SIZE                 = DEFAULT_QUEUE_SIZE,
   parameter int QUEUE_PTR_WIDTH_IN_BITS    = DEFAULT_PTR_WIDTH,
   parameter int ALMOST_FULL_THRESHOLD      = DEFAULT_ALMOST_FULL,
   parameter int ALMOST_EMPTY_THRESHOLD     = DEFAULT_ALMOST_EMPTY
) (
   input  logic                                  clk_in,
   input  logic                                  reset_in,
`ifdef THRESHOLD_FIFO_FLUSH_EN
   input  logic                                  flush_in,
`endif
   input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in,
   input  logic                                  request_valid_in,
   output logic                                  issue_ack_out,
   output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_out,
   output logic                                  request_valid_out,
   input  logic                                  issue_ack_in,
   output logic                                  is_empty_out,
   output logic                                  is_full_out,
   output logic                                  is_almost_full_out,
   output logic                                  is_almost_empty_out,
   output logic [QUEUE_PTR_WIDTH_IN_BITS:0]      occupancy_out
);

   localparam int PTR_W = QUEUE_PTR_WIDTH_IN_BITS;

   // Elaboration-time parameter sanity
   if (!is_pow2(QUEUE_SIZE) || QUEUE_SIZE < 2 || QUEUE_SIZE > 1024) begin : g_bad_size
      $error("QUEUE_SIZE must be a power of two in 2..1024");
   end
   if (QUEUE_SIZE != (1 << PTR_W)) begin : g_bad_ptr
      $error("QUEUE_PTR_WIDTH_IN_BITS must equal log2(QUEUE_SIZE)");
   end
   if (ALMOST_FULL_THRESHOLD > QUEUE_SIZE) begin : g_bad_af
      $error("ALMOST_FULL_THRESHOLD must not exceed QUEUE_SIZE");
   end
   if (ALMOST_EMPTY_THRESHOLD >= ALMOST_FULL_THRESHOLD) begin : g_bad_ae
      $error("ALMOST_EMPTY_THRESHOLD must be below ALMOST_FULL_THRESHOLD");
   end

   logic                                  flush_w;
   logic                                  push_w;
   logic                                  pop_w;
   logic [PTR_W-1:0]                      wr_ptr_w;
   logic [PTR_W-1:0]                      rd_ptr_w;
   logic                                  empty_w;
   logic                                  full_w;
   logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] mem_q [QUEUE_SIZE];

`ifdef THRESHOLD_FIFO_FLUSH_EN
   assign flush_w = flush_in;
`else
   assign flush_w = 1'b0;
`endif

   fifo_ptr_ctrl #(
      .QUEUE_SIZE (QUEUE_SIZE),
      .PTR_W      (PTR_W),
      .AF_THRESH  (ALMOST_FULL_THRESHOLD),
      .AE_THRESH  (ALMOST_EMPTY_THRESHOLD)
   ) u_ptr_ctrl (
      .clk_in         (clk_in),
      .reset_in       (reset_in),
      .push_req_i     (request_valid_in),
      .pop_req_i      (issue_ack_in),
      .flush_i        (flush_w),
      .push_o         (push_w),
      .pop_o          (pop_w),
      .wr_ptr_o       (wr_ptr_w),
      .rd_ptr_o       (rd_ptr_w),
      .occupancy_o    (occupancy_out),
      .empty_o        (empty_w),
      .full_o         (full_w),
      .almost_full_o  (is_almost_full_out),
      .almost_empty_o (is_almost_empty_out)
   );

   assign issue_ack_out     = push_w;
   assign request_valid_out = ~empty_w;
   assign is_empty_out      = empty_w;
   assign is_full_out       = full_w;

   // Head entry read straight from storage so it follows the read pointer
   // the cycle after a pop; its value is meaningless while empty.
   assign request_out = mem_q[rd_ptr_w];

   // Storage write; contents survive reset and flush, only pointers clear
   always_ff @(posedge clk_in) begin
      if (push_w && !reset_in) begin
         mem_q[wr_ptr_w] <= request_in;
      end
   end

   // pop_w is consumed inside the controller; keep it observable for debug
   logic pop_dbg_unused;
   assign pop_dbg_unused = pop_w;

endmodule

// File: tb/tb_threshold_fifo_queue.sv
// Scoreboard bench for threshold_fifo_queue: a queue-based reference
// model runs on the falling edge, checks status against its own count
// and queues expected pop data; a separate monitor compares popped data.
module tb_threshold_fifo_queue;

   localparam int W     = 64;
   localparam int DEPTH = 16;
   localparam int PTRW  = 4;
   localparam int AF    = 12;
   localparam int AE    = 4;

   logic          clk_in = 1'b0;
   logic          reset_in = 1'b0;
   logic          flush_in = 1'b0;
   logic [W-1:0]  request_in = '0;
   logic          request_valid_in = 1'b0;
   logic          issue_ack_in = 1'b0;
   logic          issue_ack_out;
   logic [W-1:0]  request_out;
   logic          request_valid_out;
   logic          is_empty_out;
   logic          is_full_out;
   logic          is_almost_full_out;
   logic          is_almost_empty_out;
   logic [PTRW:0] occupancy_out;

   int            errors = 0;
   int            checks = 0;
   bit            armed = 0;
   logic          last_ack;
   logic [W-1:0]  ref_q[$];
   logic [W-1:0]  sb_q[$];
   int            model_n;
   logic [W-1:0]  mon_exp;

   always #5 clk_in = ~clk_in;

   threshold_fifo_queue #(
      .SINGLE_ENTRY_WIDTH_IN_BITS (W),
      .QUEUE_SIZE                 (DEPTH),
      .QUEUE_PTR_WIDTH_IN_BITS    (PTRW),
      .ALMOST_FULL_THRESHOLD      (AF),
      .ALMOST_EMPTY_THRESHOLD     (AE)
   ) dut (
      .clk_in              (clk_in),
      .reset_in            (reset_in),
`ifdef THRESHOLD_FIFO_FLUSH_EN
      .flush_in            (flush_in),
`endif
      .request_in          (request_in),
      .request_valid_in    (request_valid_in),
      .issue_ack_out       (issue_ack_out),
      .request_out         (request_out),
      .request_valid_out   (request_valid_out),
      .issue_ack_in        (issue_ack_in),
      .is_empty_out        (is_empty_out),
      .is_full_out         (is_full_out),
      .is_almost_full_out  (is_almost_full_out),
      .is_almost_empty_out (is_almost_empty_out),
      .occupancy_out       (occupancy_out)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: status from queue size, then apply this edge's push/pop
   always @(negedge clk_in) begin
      model_n = ref_q.size();
      if (armed) begin
         chk("occupancy",    64'(occupancy_out),       64'(model_n));
         chk("is_empty",     64'(is_empty_out),        64'(model_n == 0));
         chk("is_full",      64'(is_full_out),         64'(model_n == DEPTH));
         chk("almost_full",  64'(is_almost_full_out),  64'(model_n >= AF));
         chk("almost_empty", 64'(is_almost_empty_out), 64'(model_n <= AE));
         chk("valid_out",    64'(request_valid_out),   64'(model_n != 0));
         chk("issue_ack",    64'(issue_ack_out),
             64'(request_valid_in && model_n < DEPTH && !flush_in));
      end
      if (reset_in) begin
         ref_q.delete();
         armed = 1;
      end else if (armed) begin
         if (flush_in) begin
            ref_q.delete();
         end else begin
            if (issue_ack_in && model_n > 0) sb_q.push_back(ref_q.pop_front());
            if (request_valid_in && model_n < DEPTH) begin
               ref_q.push_back(request_in);
               $display("push data=%h occ_before=%0d", request_in, model_n);
            end
         end
      end
   end

   // Monitor: whenever the DUT hands over its head entry, compare with the scoreboard
   always @(negedge clk_in) begin
      #1;
      if (armed && !reset_in && !flush_in && request_valid_out && issue_ack_in) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected: got %h expected no pop", request_out);
         end else begin
            mon_exp = sb_q.pop_front();
            chk("pop_data", request_out, mon_exp);
            $display("pop  data=%h expected=%h", request_out, mon_exp);
         end
      end
   end

   task automatic step(input logic v, input logic [W-1:0] d, input logic a,
                       input logic f, input logic r);
      request_valid_in = v;
      request_in       = d;
      issue_ack_in     = a;
      flush_in         = f;
      reset_in         = r;
      @(negedge clk_in);
      last_ack = issue_ack_out;
      @(posedge clk_in);
      #1;
   endtask

   task automatic fill(input int n);
      for (int i = 0; i < n; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int k = 0; k < 3 * DEPTH && !is_empty_out; k++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("drain_empty", 64'(is_empty_out), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acks;
      logic [W-1:0] all_ones;
      all_ones = '1;
      @(posedge clk_in);
      #1;
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Basic order: 8 pushes of all-ones minus index, then 8 pops
      for (int i = 0; i < 8; i++) step(1'b1, all_ones - W'(i), 1'b0, 1'b0, 1'b0);
      chk("basic_occ8", 64'(occupancy_out), 64'd8);
      drain();

      // Pops while empty are no-ops
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("empty_pop_occ", 64'(occupancy_out), 64'd0);

      // Hold valid for 32 cycles: exactly DEPTH acks
      acks = 0;
      for (int i = 0; i < 32; i++) begin
         step(1'b1, 64'h1000 + W'(i), 1'b0, 1'b0, 1'b0);
         if (last_ack) acks++;
      end
      chk("full_ack_count", 64'(acks), 64'(DEPTH));
      chk("full_flag", 64'(is_full_out), 64'd1);

      // Full with simultaneous push and pop: pop only
      step(1'b1, 64'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
      chk("full_pop_ack", 64'(last_ack), 64'd0);
      chk("full_pop_occ", 64'(occupancy_out), 64'(DEPTH - 1));
      drain();

      // Steady state at occupancy 5 for 40 cycles, pointers wrap
      fill(5);
      for (int i = 0; i < 40; i++) step(1'b1, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0);
      chk("steady_occ", 64'(occupancy_out), 64'd5);
      drain();

`ifdef THRESHOLD_FIFO_FLUSH_EN
      // Flush at occupancy 9 with a same-cycle push
      fill(9);
      step(1'b1, 64'h5A5A, 1'b0, 1'b1, 1'b0);
      chk("flush_ack", 64'(last_ack), 64'd0);
      chk("flush_occ", 64'(occupancy_out), 64'd0);
`endif

      // Reset in mid-operation at occupancy 7
      fill(7);
      step(1'b1, 64'h7777, 1'b0, 1'b0, 1'b1);
      chk("reset_occ", 64'(occupancy_out), 64'd0);
      chk("reset_empty", 64'(is_empty_out), 64'd1);
      chk("reset_almost_empty", 64'(is_almost_empty_out), 64'd1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), {$urandom, $urandom},
              1'($urandom_range(0, 2) == 0), 1'b0, 1'b0);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
